// File: rtl/gon_pkg.sv
// Shared defaults and register-state type for the GON psum gather network.
package gon_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 64;
  localparam int unsigned ROW_TAG_WIDTH_DEF = 4;
  localparam int unsigned COL_TAG_WIDTH_DEF = 4;
  localparam int unsigned NUM_OF_ROWS_DEF   = 12;
  localparam int unsigned NUM_OF_COLS_DEF   = 14;
  localparam int unsigned XFER_CNT_WIDTH    = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } reg_state_e;

endpackage

// File: rtl/gon_xbus.sv
// One row of the gather network: picks the lowest matching PE column and
// holds its word in a single-entry row register until the top drains it.
module gon_xbus
  import gon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ROW_TAG_WIDTH = ROW_TAG_WIDTH_DEF,
  parameter int unsigned COL_TAG_WIDTH = COL_TAG_WIDTH_DEF,
  parameter int unsigned NUM_OF_COLS   = NUM_OF_COLS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROW_TAG_WIDTH-1:0] row_tag,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  input  logic [ROW_TAG_WIDTH-1:0] row_id,
  input  logic [COL_TAG_WIDTH-1:0] col_id  [NUM_OF_COLS],
  input  logic [DATA_WIDTH-1:0]    data_in [NUM_OF_COLS],
  input  logic [0:NUM_OF_COLS-1]   enable_in,
  input  logic                     drain,
  output logic [0:NUM_OF_COLS-1]   ready_c,
  output logic                     full,
  output logic [DATA_WIDTH-1:0]    data
);

  reg_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  row_hit;
  logic                  can_accept;
  logic                  sel_found;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  load;

  // Column select and row-register next state; the register may refill in
  // the same cycle it is drained.
  always_comb begin
    ready_c    = '0;
    sel_found  = 1'b0;
    sel_data   = '0;
    row_hit    = (row_id == row_tag);
    can_accept = (state_q == EMPTY) || drain;
    for (int c = 0; c < int'(NUM_OF_COLS); c++) begin
      if (!sel_found && enable_in[c] && row_hit && (col_id[c] == col_tag)) begin
        sel_found  = 1'b1;
        sel_data   = data_in[c];
        ready_c[c] = can_accept && !reset;
      end
    end
    load    = sel_found && can_accept && !reset;
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = sel_data;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign full = (state_q == FULL);
  assign data = data_q;

endmodule

// File: rtl/gon.sv
// GON: gathers tagged psum words from a PE array into one output stream.
// Optional GON_XFER_CNT_EN adds a 16-bit output-handshake counter port.
module gon
  import gon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ROW_TAG_WIDTH = ROW_TAG_WIDTH_DEF,
  parameter int unsigned COL_TAG_WIDTH = COL_TAG_WIDTH_DEF,
  parameter int unsigned NUM_OF_ROWS   = NUM_OF_ROWS_DEF,
  parameter int unsigned NUM_OF_COLS   = NUM_OF_COLS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROW_TAG_WIDTH-1:0] row_tag,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  input  logic [ROW_TAG_WIDTH-1:0] row_id     [NUM_OF_ROWS],
  input  logic [COL_TAG_WIDTH-1:0] col_id     [NUM_OF_ROWS][NUM_OF_COLS],
  input  logic [DATA_WIDTH-1:0]    data_in    [NUM_OF_ROWS][NUM_OF_COLS],
  input  logic [0:NUM_OF_COLS-1]   enable_in  [NUM_OF_ROWS],
  output logic [0:NUM_OF_COLS-1]   ready_out  [NUM_OF_ROWS],
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     enable_out,
  input  logic                     ready_in
`ifdef GON_XFER_CNT_EN
  ,
  output logic [XFER_CNT_WIDTH-1:0] xfer_count
`endif
);

  logic [NUM_OF_ROWS-1:0] row_full;
  logic [NUM_OF_ROWS-1:0] row_drain;
  logic [DATA_WIDTH-1:0]  row_data [NUM_OF_ROWS];

  reg_state_e             out_state_q, out_state_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_can_accept;
  logic                   drain_found;
  logic [DATA_WIDTH-1:0]  drain_data;

  for (genvar r = 0; r < int'(NUM_OF_ROWS); r++) begin : g_row
    gon_xbus #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ROW_TAG_WIDTH(ROW_TAG_WIDTH),
      .COL_TAG_WIDTH(COL_TAG_WIDTH),
      .NUM_OF_COLS  (NUM_OF_COLS)
    ) u_xbus (
      .clk      (clk),
      .reset    (reset),
      .row_tag  (row_tag),
      .col_tag  (col_tag),
      .row_id   (row_id[r]),
      .col_id   (col_id[r]),
      .data_in  (data_in[r]),
      .enable_in(enable_in[r]),
      .drain    (row_drain[r]),
      .ready_c  (ready_out[r]),
      .full     (row_full[r]),
      .data     (row_data[r])
    );
  end

  // Lowest full row wins the output register whenever it can take a word.
  always_comb begin
    row_drain      = '0;
    drain_found    = 1'b0;
    drain_data     = '0;
    out_can_accept = (out_state_q == EMPTY) || ready_in;
    for (int r = 0; r < int'(NUM_OF_ROWS); r++) begin
      if (!drain_found && row_full[r]) begin
        drain_found  = 1'b1;
        drain_data   = row_data[r];
        row_drain[r] = out_can_accept;
      end
    end
    out_state_d = out_state_q;
    out_data_d  = out_data_q;
    if (out_can_accept) begin
      if (drain_found) begin
        out_state_d = FULL;
        out_data_d  = drain_data;
      end else begin
        out_state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_q <= EMPTY;
      out_data_q  <= '0;
    end else begin
      out_state_q <= out_state_d;
      out_data_q  <= out_data_d;
    end
  end

  assign enable_out = (out_state_q == FULL);
  assign data_out   = out_data_q;

`ifdef GON_XFER_CNT_EN
  logic [XFER_CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  // Free-running wrap on every output handshake.
  always_comb begin
    xfer_count_d = xfer_count_q;
    if (enable_out && ready_in) begin
      xfer_count_d = xfer_count_q + XFER_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_gon.sv
// Directed scoreboard bench for gon; define GON_XFER_CNT_EN to also
// exercise the transfer counter.
module tb_gon;
  import gon_pkg::*;

  localparam int unsigned DW = DATA_WIDTH_DEF;
  localparam int unsigned RW = ROW_TAG_WIDTH_DEF;
  localparam int unsigned CW = COL_TAG_WIDTH_DEF;
  localparam int unsigned NR = NUM_OF_ROWS_DEF;
  localparam int unsigned NC = NUM_OF_COLS_DEF;

  logic          clk;
  logic          reset;
  logic [RW-1:0] row_tag;
  logic [CW-1:0] col_tag;
  logic [RW-1:0] row_id    [NR];
  logic [CW-1:0] col_id    [NR][NC];
  logic [DW-1:0] data_in   [NR][NC];
  logic [0:NC-1] enable_in [NR];
  logic [0:NC-1] ready_out [NR];
  logic [DW-1:0] data_out;
  logic          enable_out;
  logic          ready_in;
`ifdef GON_XFER_CNT_EN
  logic [15:0]   xfer_count;
`endif

  gon dut (
    .clk       (clk),
    .reset     (reset),
    .row_tag   (row_tag),
    .col_tag   (col_tag),
    .row_id    (row_id),
    .col_id    (col_id),
    .data_in   (data_in),
    .enable_in (enable_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .enable_out(enable_out),
    .ready_in  (ready_in)
`ifdef GON_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            n_out  = 0;
  logic [DW-1:0] sb_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_ready();
    int n = 0;
    for (int r = 0; r < int'(NR); r++)
      for (int c = 0; c < int'(NC); c++)
        if (ready_out[r][c] === 1'b1) n++;
    return n;
  endfunction

  // Sample both interfaces mid-cycle, then advance to just after the next edge.
  task automatic tick();
    logic [DW-1:0] exp;
    @(negedge clk);
    for (int r = 0; r < int'(NR); r++)
      for (int c = 0; c < int'(NC); c++)
        if (enable_in[r][c] && ready_out[r][c] === 1'b1) sb_q.push_back(data_in[r][c]);
    if (!reset && enable_out === 1'b1 && ready_in) begin
      n_out++;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_pop observed=unexpected word %0h expected=no output", data_out);
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check("sb_data", data_out, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic hs;
    int   sent;
    int   base;
    reset    = 1'b1;
    ready_in = 1'b1;
    row_tag  = RW'(3);
    col_tag  = CW'(5);
    for (int r = 0; r < int'(NR); r++) begin
      row_id[r]    = RW'(r);
      enable_in[r] = '0;
      for (int c = 0; c < int'(NC); c++) begin
        col_id[r][c]  = CW'(c);
        data_in[r][c] = '0;
      end
    end
    data_in[3][5]   = 64'hA5;
    enable_in[3][5] = 1'b1;

    // Reset: matching PE offered but ready must stay low.
    tick();
    tick();
    check("rst_ready", DW'(count_ready()), 0);
    check("rst_enable_out", DW'(enable_out), 0);
    check("rst_data_out", data_out, 0);

    // Single word from PE[3][5], two-cycle latency.
    reset = 1'b0;
    #1;
    check("t1_ready35", DW'(ready_out[3][5]), 1);
    check("t1_ready_count", DW'(count_ready()), 1);
    tick();
    enable_in[3][5] = 1'b0;
    check("t1_lat_n", DW'(enable_out), 0);
    tick();
    check("t1_enable_out", DW'(enable_out), 1);
    check("t1_data_out", data_out, 64'hA5);
    tick();
    check("t1_done", DW'(enable_out), 0);

    // Two matches in one row: lower column first.
    row_tag         = RW'(2);
    col_tag         = CW'(1);
    col_id[2][4]    = CW'(1);
    data_in[2][1]   = 64'h21;
    data_in[2][4]   = 64'h24;
    enable_in[2][1] = 1'b1;
    enable_in[2][4] = 1'b1;
    #1;
    check("t2_ready21", DW'(ready_out[2][1]), 1);
    check("t2_ready24_blocked", DW'(ready_out[2][4]), 0);
    tick();
    enable_in[2][1] = 1'b0;
    #1;
    check("t2_ready24", DW'(ready_out[2][4]), 1);
    tick();
    enable_in[2][4] = 1'b0;
    check("t2_first", data_out, 64'h21);
    tick();
    check("t2_second", data_out, 64'h24);
    check("t2_second_en", DW'(enable_out), 1);
    tick();
    check("t2_done", DW'(enable_out), 0);
    col_id[2][4] = CW'(4);

    // Full-rate stream from one PE with ready_in high.
    row_tag         = RW'(5);
    col_tag         = CW'(7);
    enable_in[5][7] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_in[5][7] = 64'h100 + DW'(k);
      #1;
      check("t3_stream_ready", DW'(ready_out[5][7]), 1);
      tick();
      if (k >= 1) check("t3_stream_out", data_out, 64'h100 + DW'(k - 1));
    end
    enable_in[5][7] = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Backpressure: 1,2,3 with ready_in low for five cycles.
    row_tag         = RW'(0);
    col_tag         = CW'(0);
    ready_in        = 1'b0;
    sent            = 0;
    data_in[0][0]   = 64'd1;
    enable_in[0][0] = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 7) ready_in = 1'b1;
      #1;
      hs = enable_in[0][0] && (ready_out[0][0] === 1'b1);
      tick();
      if (hs) begin
        sent++;
        if (sent == 3) enable_in[0][0] = 1'b0;
        else data_in[0][0] = DW'(sent + 1);
      end
      if (cyc >= 2 && cyc < 7) begin
        check("t4_hold_data", data_out, 64'd1);
        check("t4_hold_en", DW'(enable_out), 1);
      end
    end
    check("t4_sent", DW'(sent), 3);

    // Non-matching column never handshakes.
    row_tag         = RW'(6);
    col_tag         = CW'(2);
    enable_in[6][3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_no_ready", DW'(count_ready()), 0);
      tick();
      check("t5_no_out", DW'(enable_out), 0);
    end
    enable_in[6][3] = 1'b0;

    // Tag change with a word already captured.
    row_tag         = RW'(1);
    col_tag         = CW'(1);
    ready_in        = 1'b0;
    data_in[1][1]   = 64'h11;
    enable_in[1][1] = 1'b1;
    tick();
    enable_in[1][1] = 1'b0;
    tick();
    row_tag         = RW'(4);
    col_tag         = CW'(4);
    data_in[4][4]   = 64'h44;
    enable_in[4][4] = 1'b1;
    tick();
    enable_in[4][4] = 1'b0;
    check("t6_held_old", data_out, 64'h11);
    ready_in = 1'b1;
    tick();
    check("t6_new_word", data_out, 64'h44);
    for (int k = 0; k < 3; k++) tick();

    // Reset with row and output registers both full.
    row_tag         = RW'(0);
    col_tag         = CW'(0);
    ready_in        = 1'b0;
    data_in[0][0]   = 64'h77;
    enable_in[0][0] = 1'b1;
    tick();
    data_in[0][0] = 64'h78;
    tick();
    check("t7_pre_full", DW'(enable_out), 1);
    reset = 1'b1;
    #1;
    check("t7_rst_ready", DW'(count_ready()), 0);
    tick();
    reset           = 1'b0;
    enable_in[0][0] = 1'b0;
    sb_q.delete();
    check("t7_rst_en", DW'(enable_out), 0);
    check("t7_rst_data", data_out, 0);
`ifdef GON_XFER_CNT_EN
    check("t7_rst_cnt", DW'(xfer_count), 0);
`endif
    ready_in = 1'b1;
    tick();
    tick();
    check("t7_row_cleared", DW'(enable_out), 0);

`ifdef GON_XFER_CNT_EN
    // 65537 output handshakes wrap the counter to 1.
    base            = n_out;
    sent            = 0;
    data_in[0][0]   = 64'h5A;
    enable_in[0][0] = 1'b1;
    for (int i = 0; i < 70000 && (sent < 65537 || n_out - base < 65537); i++) begin
      #1;
      hs = enable_in[0][0] && (ready_out[0][0] === 1'b1);
      tick();
      if (hs) begin
        sent++;
        if (sent == 65537) enable_in[0][0] = 1'b0;
      end
    end
    tick();
    check("t8_handshakes", DW'(n_out - base), 65537);
    check("t8_xfer_wrap", DW'(xfer_count), 1);
`else
    base = n_out;
    sent = 0;
`endif

    check("sb_empty", DW'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gon.md
GON -- requirements
Module: gon

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, psum word width.
REQ-002 SHALL have parameter ROW_TAG_WIDTH, default 4, row tag/id width.
REQ-003 SHALL have parameter COL_TAG_WIDTH, default 4, column tag/id width.
REQ-004 SHALL have parameter NUM_OF_ROWS, default 12, PE rows.
REQ-005 SHALL have parameter NUM_OF_COLS, default 14, PE columns.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port row_tag  in  ROW_TAG_WIDTH  row to collect from.
REQ-009 SHALL have port col_tag  in  COL_TAG_WIDTH  column to collect from.
REQ-010 SHALL have port row_id  in  ROW_TAG_WIDTH x [NUM_OF_ROWS]  per-row id.
REQ-011 SHALL have port col_id  in  COL_TAG_WIDTH x [NUM_OF_ROWS][NUM_OF_COLS]  per-PE column id.
REQ-012 SHALL have port data_in  in  DATA_WIDTH x [NUM_OF_ROWS][NUM_OF_COLS]  PE psum data.
REQ-013 SHALL have port enable_in  in  [0:NUM_OF_COLS-1] x [NUM_OF_ROWS]  PE valid.
REQ-014 SHALL have port ready_out  out  [0:NUM_OF_COLS-1] x [NUM_OF_ROWS]  ready to each PE.
REQ-015 SHALL have port data_out  out  DATA_WIDTH  psum to global buffer.
REQ-016 SHALL have port enable_out  out  1  data_out valid.
REQ-017 SHALL have port ready_in  in  1  global buffer ready.

Function
REQ-018 SHALL transfer a word on any interface only in a cycle where its enable and ready are both high.
REQ-019 SHALL, per row r, set match[r][c] = enable_in[r][c] && row_id[r]==row_tag && col_id[r][c]==col_tag.
REQ-020 SHALL keep one row register (EMPTY/FULL) per row; row_can_accept[r] = EMPTY, or FULL and being drained this cycle.
REQ-021 SHALL assert ready_out[r][c] only for the lowest-index c with match[r][c] high, and only when row_can_accept[r]; all other ready_out bits low.
REQ-022 SHALL keep one output register (EMPTY/FULL); out_can_accept = EMPTY || ready_in.
REQ-023 SHALL drain into the output register the lowest-index FULL row register when out_can_accept; other rows hold.
REQ-024 SHALL give latency of 2 cycles: PE handshake at edge N -> enable_out high after edge N+1.
REQ-025 SHALL sustain one word per cycle when ready_in stays high and a single PE streams.
REQ-026 SHALL hold data_out/enable_out stable while enable_out && !ready_in.
REQ-027 SHALL, on simultaneous output handshake and new load, take the new word with no bubble.
REQ-028 SHALL, when tags change, drain words already in registers unchanged; only new acceptances use the new tags.
REQ-029 SHALL never drop or duplicate a word; combinational ready_out SHALL not depend on enable_out.

Reset
REQ-030 SHALL, while reset is high at a clock edge, clear all registers to EMPTY, data to 0, enable_out to 0.
REQ-031 SHALL hold ready_out all-zero during reset; words in flight SHALL be discarded.

Configuration
REQ-032 SHALL compile, with GON_XFER_CNT_EN defined, an output xfer_count (16 bits) counting output handshakes, reset to 0, wrapping 0xFFFF->0.
REQ-033 SHALL, without GON_XFER_CNT_EN, omit the xfer_count port and counter entirely.

Structure
REQ-034 SHALL place default width/size constants and the reg-state enum (EMPTY, FULL) in package gon_pkg.
REQ-035 SHALL implement each row's column selection and row register as sub-module gon_xbus, instantiated per row.

Verification
REQ-036 SHALL cover: row_tag=3,col_tag=5, PE[3][5] sends 0xA5 with ready_in=1 -> ready_out[3][5]=1, data_out=0xA5, enable_out 2 cycles later.
REQ-037 SHALL cover: PE[2][1] and PE[2][4] both match -> [2][1] served first, [2][4] next cycle.
REQ-038 SHALL cover: ready_in=0 for 5 cycles during stream of 1,2,3 -> data_out holds 1, then 1,2,3 in order, no loss.
REQ-039 SHALL cover: PE with non-matching col_id asserts enable_in -> ready_out stays 0, enable_out stays 0.
REQ-040 SHALL cover: reset asserted with both registers FULL -> next cycle enable_out=0, all ready_out=0, xfer_count=0 (if enabled).
REQ-041 SHALL cover: 65537 output handshakes with GON_XFER_CNT_EN -> xfer_count=1.
